// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
// Two-stage pipelined WIDTH-bit bitwise logic unit. Each transaction selects
// its function with an opcode. Valid/ready handshakes are used on both sides.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand transaction present
//   in_ready    block accepts the operand transaction this cycle
//   op          function select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 NOT b,
//               5 XOR, 6 XNOR, 7 illegal
//   a, b        operands
//   out_valid   result transaction present
//   out_ready   sink accepts the result this cycle
//   result      bitwise result (0 for an illegal opcode)
//   op_out      opcode that produced result
//   zero        result == 0
//   parity      XOR-reduction of result
//   illegal     op_out was 7
//   done_count  number of results handed off (wraps)
// ---------------------------------------------------------------------------
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       op_out,
   output logic             zero,
   output logic             parity,
   output logic             illegal,
   output logic [CNT_W-1:0] done_count
);

   // Stage 1: captured operands
   logic             s1_v_q;
   logic [2:0]       s1_op_q;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;

   // Stage 2: computed result and flags
   logic             s2_v_q;
   logic [WIDTH-1:0] result_q;
   logic [2:0]       op_out_q;
   logic             zero_q;
   logic             parity_q;
   logic             illegal_q;
   logic [CNT_W-1:0] cnt_q;

   // Next-state values for stage 2, computed from stage 1
   logic [WIDTH-1:0] result_d;
   logic             zero_d;
   logic             parity_d;
   logic             illegal_d;

   logic s1_adv;
   logic s2_adv;

   // A stage may load when it is empty or its contents move on this cycle.
   // in_ready therefore depends combinationally on out_ready.
   assign s2_adv   = !s2_v_q || out_ready;
   assign s1_adv   = !s1_v_q || s2_adv;
   assign in_ready = s1_adv;

   always_comb begin
      result_d  = '0;
      illegal_d = 1'b0;
      case (s1_op_q)
         3'd0:    result_d = s1_a_q & s1_b_q;
         3'd1:    result_d = s1_a_q | s1_b_q;
         3'd2:    result_d = ~(s1_a_q & s1_b_q);
         3'd3:    result_d = ~(s1_a_q | s1_b_q);
         3'd4:    result_d = ~s1_b_q;
         3'd5:    result_d = s1_a_q ^ s1_b_q;
         3'd6:    result_d = ~(s1_a_q ^ s1_b_q);
         default: begin
            // Illegal opcode still flows through with a zero result
            result_d  = '0;
            illegal_d = 1'b1;
         end
      endcase
      zero_d   = (result_d == '0);
      parity_d = ^result_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q  <= 1'b0;
         s1_op_q <= '0;
         s1_a_q  <= '0;
         s1_b_q  <= '0;
      end else if (s1_adv) begin
         s1_v_q <= in_valid;
         // Operand registers only change when a real transaction enters
         if (in_valid) begin
            s1_op_q <= op;
            s1_a_q  <= a;
            s1_b_q  <= b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q    <= 1'b0;
         result_q  <= '0;
         op_out_q  <= '0;
         zero_q    <= 1'b0;
         parity_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else if (s2_adv) begin
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            result_q  <= result_d;
            op_out_q  <= s1_op_q;
            zero_q    <= zero_d;
            parity_q  <= parity_d;
            illegal_q <= illegal_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (s2_v_q && out_ready) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_valid  = s2_v_q;
   assign result     = result_q;
   assign op_out     = op_out_q;
   assign zero       = zero_q;
   assign parity     = parity_q;
   assign illegal    = illegal_q;
   assign done_count = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
// Directed-vector bench with a scoreboard queue. Stimulus pushes the
// hand-computed expected response when a transaction is accepted; a monitor
// pops and compares on every output handshake. A second instance with a
// 2-bit counter shares all inputs and exercises counter wrap.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

   typedef struct {
      logic [7:0] res;
      logic [2:0] op;
      logic       z;
      logic       p;
      logic       il;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = '0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  result;
   logic [2:0]  op_out;
   logic        zero;
   logic        parity;
   logic        illegal;
   logic [15:0] done_count;

   logic        w_in_ready;
   logic        w_out_valid;
   logic [7:0]  w_result;
   logic [2:0]  w_op_out;
   logic        w_zero;
   logic        w_parity;
   logic        w_illegal;
   logic [1:0]  w_done_count;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   int   exp_cnt  = 0;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .op_out(op_out), .zero(zero), .parity(parity),
      .illegal(illegal), .done_count(done_count)
   );

   logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
      .op(op), .a(a), .b(b), .out_valid(w_out_valid), .out_ready(out_ready),
      .result(w_result), .op_out(w_op_out), .zero(w_zero), .parity(w_parity),
      .illegal(w_illegal), .done_count(w_done_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Monitor: compare on each output handshake, sampled on the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 32'(result), 32'hDEAD);
            end else begin
               e = sb.pop_front();
               $display("out: op=%0d result=%02h zero=%0b parity=%0b illegal=%0b count=%0d",
                        op_out, result, zero, parity, illegal, done_count);
               check("result",  32'(result),  32'(e.res));
               check("op_out",  32'(op_out),  32'(e.op));
               check("zero",    32'(zero),    32'(e.z));
               check("parity",  32'(parity),  32'(e.p));
               check("illegal", 32'(illegal), 32'(e.il));
               check("done_count", 32'(done_count), 32'(exp_cnt));
               check("wrap_count", 32'(w_done_count), 32'(exp_cnt % 4));
               exp_cnt++;
            end
         end
      end
   end

   // Drive a transaction at posedge+1; wait (bounded) until it is accepted.
   // Returns 1 time unit after the accepting edge, inputs still driven.
   task automatic send(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] r, input logic z, input logic p, input logic il);
      exp_t e;
      bit   done = 0;
      in_valid = 1'b1;
      op = o;
      a  = va;
      b  = vb;
      for (int i = 0; i < 50 && !done; i++) begin
         #1;
         if (in_ready) begin
            e.res = r; e.op = o; e.z = z; e.p = p; e.il = il;
            sb.push_back(e);
            $display("in : op=%0d a=%02h b=%02h expect=%02h", o, va, vb, r);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check("accept_timeout", 32'(in_ready), 32'h1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && !out_valid) done = 1;
      end
      if (!done) check("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_in_ready",  32'(in_ready),  32'h1);
      check("rst_result",    32'(result),    32'h0);
      check("rst_count",     32'(done_count), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Truth-table sweep, back-to-back, with latency checks on the first
      send(3'd0, 8'h0F, 8'h33, 8'h03, 1'b0, 1'b0, 1'b0);
      check("lat_after_accept", 32'(out_valid), 32'h0);
      send(3'd1, 8'h0F, 8'h33, 8'h3F, 1'b0, 1'b0, 1'b0);
      check("lat_next_edge", 32'(out_valid), 32'h1);
      send(3'd2, 8'h0F, 8'h33, 8'hFC, 1'b0, 1'b0, 1'b0);
      send(3'd3, 8'h0F, 8'h33, 8'hC0, 1'b0, 1'b0, 1'b0);
      send(3'd4, 8'h0F, 8'h33, 8'hCC, 1'b0, 1'b0, 1'b0);
      send(3'd5, 8'h0F, 8'h33, 8'h3C, 1'b0, 1'b0, 1'b0);
      send(3'd6, 8'h0F, 8'h33, 8'hC3, 1'b0, 1'b0, 1'b0);
      idle();
      drain();
      check("sweep_count", 32'(done_count), 32'd7);

      // Flags
      send(3'd5, 8'hA5, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0);
      send(3'd1, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
      // Illegal opcode
      send(3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
      idle();
      drain();
      check("illegal_count", 32'(done_count), 32'd10);

      // Backpressure: two accepted, third refused while out_ready is low
      out_ready = 1'b0;
      send(3'd0, 8'hFF, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0);
      send(3'd5, 8'h0F, 8'h01, 8'h0E, 1'b0, 1'b1, 1'b0);
      in_valid = 1'b1;
      op = 3'd4; a = 8'h00; b = 8'h7F;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready",  32'(in_ready),  32'h0);
         check("bp_out_valid", 32'(out_valid), 32'h1);
         check("bp_result",    32'(result),    32'h81);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(3'd4, 8'h00, 8'h7F, 8'h80, 1'b0, 1'b1, 1'b0);
      idle();
      drain();
      check("bp_count", 32'(done_count), 32'd13);

      // Reset mid-flight with two transactions in the pipe
      send(3'd1, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0);
      send(3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
      idle();
      rst_n = 1'b0;
      sb.delete();
      exp_cnt = 0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid),  32'h0);
      check("mid_rst_result",    32'(result),     32'h0);
      check("mid_rst_op_out",    32'(op_out),     32'h0);
      check("mid_rst_flags",     32'({zero, parity, illegal}), 32'h0);
      check("mid_rst_count",     32'(done_count), 32'h0);
      check("mid_rst_in_ready",  32'(in_ready),   32'h1);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_empty", 32'(out_valid), 32'h0);
      send(3'd6, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0);
      idle();
      check("post_rst_lat0", 32'(out_valid), 32'h0);
      @(posedge clk);
      #1;
      check("post_rst_lat1", 32'(out_valid), 32'h1);
      drain();
      check("final_count", 32'(done_count), 32'd1);
      check("final_wrap",  32'(w_done_count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
